// File: rtl/anim_sprite_drawer_if.sv
// Bundle between the game-state logic / frame-buffer writer and the sprite address generator.
// The master drives the sequencing controls and coordinates; the slave returns the address and hit flags.
interface anim_sprite_drawer_if #(
    parameter int ADDR_W  = 18,
    parameter int COORD_W = 10
);
    logic               frame_tick;
    logic               anim_en;
    logic               anim_restart;
    logic [1:0]         mode;
    logic               mirror;
    logic [COORD_W-1:0] WriteX;
    logic [COORD_W-1:0] WriteY;
    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic [COORD_W-1:0] PosX;
    logic [COORD_W-1:0] PosY;
    logic               sprite_on_wr;
    logic               sprite_on_dr;
    logic [ADDR_W-1:0]  address;
    logic [2:0]         frame_idx;
    logic               anim_done;

    modport master (
        output frame_tick, anim_en, anim_restart, mode, mirror,
        output WriteX, WriteY, DrawX, DrawY, PosX, PosY,
        input  sprite_on_wr, sprite_on_dr, address, frame_idx, anim_done
    );

    modport slave (
        input  frame_tick, anim_en, anim_restart, mode, mirror,
        input  WriteX, WriteY, DrawX, DrawY, PosX, PosY,
        output sprite_on_wr, sprite_on_dr, address, frame_idx, anim_done
    );
endinterface

// File: rtl/anim_sprite_drawer.sv
// Animated sprite ROM address generator: frame sequencer (loop / one-shot / ping-pong)
// plus a registered write-side address/hit and a combinational draw-side hit.
module anim_sprite_drawer #(
    parameter int SIZE_X     = 88,
    parameter int SIZE_Y     = 94,
    parameter int NUM_FRAMES = 2,
    parameter int FRAME_BASE = 207867,
    parameter int HOLD_TICKS = 10,
    parameter int ADDR_W     = 18,
    parameter int COORD_W    = 10
) (
    input logic                  Clk50,
    input logic                  Reset_n,
    anim_sprite_drawer_if.slave  bus
);

    localparam int                 FRAME_PIX = SIZE_X * SIZE_Y;
    localparam int                 HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [2:0]         LAST_IDX  = 3'(NUM_FRAMES - 1);
    localparam logic [COORD_W:0]   SX_EXT    = (COORD_W+1)'(SIZE_X);
    localparam logic [COORD_W:0]   SY_EXT    = (COORD_W+1)'(SIZE_Y);
    localparam logic [COORD_W-1:0] SX_M1     = COORD_W'(SIZE_X - 1);

    typedef enum logic {PLAY, DONE} state_t;

    state_t             state, state_nx;
    logic [2:0]         frame_idx_q, idx_nx;
    logic [HOLD_W-1:0]  hold_cnt, hold_nx;
    logic               dir_bwd, dir_nx;

    logic [COORD_W-1:0] dist_x_p0, dist_y_p0, col_p0;
    logic [ADDR_W-1:0]  frame_start_p0, offset_p0, addr_p0;
    logic               hit_wr_p0;
    logic [ADDR_W-1:0]  addr_p1;
    logic               hit_wr_p1;

    // Box test at COORD_W+1 bits so a sprite hanging off the right/bottom edge never wraps.
    function automatic logic in_box(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                                    input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py);
        logic [COORD_W:0] x_end, y_end;
        x_end = {1'b0, px} + SX_EXT;
        y_end = {1'b0, py} + SY_EXT;
        return (x >= px) && ({1'b0, x} < x_end) && (y >= py) && ({1'b0, y} < y_end);
    endfunction

    always_ff @(posedge Clk50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= PLAY;
            frame_idx_q <= '0;
            hold_cnt    <= '0;
            dir_bwd     <= 1'b0;
        end else begin
            state       <= state_nx;
            frame_idx_q <= idx_nx;
            hold_cnt    <= hold_nx;
            dir_bwd     <= dir_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = frame_idx_q;
        hold_nx  = hold_cnt;
        dir_nx   = dir_bwd;
        if (bus.anim_restart) begin
            state_nx = PLAY;
            idx_nx   = '0;
            hold_nx  = '0;
            dir_nx   = 1'b0;
        end else if (bus.frame_tick && bus.anim_en && (state == PLAY)) begin
            if (hold_cnt != HOLD_LAST) begin
                hold_nx = hold_cnt + HOLD_W'(1);
            end else begin
                hold_nx = '0;
                case (bus.mode)
                    2'b01: begin
                        if (frame_idx_q >= LAST_IDX) begin
                            state_nx = DONE;
                        end else begin
                            idx_nx = frame_idx_q + 3'd1;
                            if (frame_idx_q + 3'd1 == LAST_IDX) state_nx = DONE;
                        end
                    end
                    2'b10: begin
                        // Turn around on the end frame itself so it is not shown twice.
                        if (LAST_IDX == 3'd0) begin
                            idx_nx = '0;
                        end else if (!dir_bwd) begin
                            if (frame_idx_q >= LAST_IDX) begin
                                dir_nx = 1'b1;
                                idx_nx = frame_idx_q - 3'd1;
                            end else begin
                                idx_nx = frame_idx_q + 3'd1;
                            end
                        end else begin
                            if (frame_idx_q == 3'd0) begin
                                dir_nx = 1'b0;
                                idx_nx = 3'd1;
                            end else begin
                                idx_nx = frame_idx_q - 3'd1;
                            end
                        end
                    end
                    default: begin
                        idx_nx = (frame_idx_q >= LAST_IDX) ? 3'd0 : frame_idx_q + 3'd1;
                    end
                endcase
            end
        end
    end

    // Stage p0: combinational address from the write coordinate and the current frame.
    always_comb begin
        dist_x_p0      = bus.WriteX - bus.PosX;
        dist_y_p0      = bus.WriteY - bus.PosY;
        col_p0         = bus.mirror ? (SX_M1 - dist_x_p0) : dist_x_p0;
        frame_start_p0 = ADDR_W'(FRAME_BASE) + ADDR_W'(32'(frame_idx_q) * FRAME_PIX);
        offset_p0      = ADDR_W'(32'(dist_y_p0) * SIZE_X + 32'(col_p0));
        hit_wr_p0      = in_box(bus.WriteX, bus.WriteY, bus.PosX, bus.PosY);
        addr_p0        = hit_wr_p0 ? (frame_start_p0 + offset_p0) : frame_start_p0;
    end

    // Stage p1: registered address and its matching hit flag.
    always_ff @(posedge Clk50 or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_p1   <= ADDR_W'(FRAME_BASE);
            hit_wr_p1 <= 1'b0;
        end else begin
            addr_p1   <= addr_p0;
            hit_wr_p1 <= hit_wr_p0;
        end
    end

    assign bus.address      = addr_p1;
    assign bus.sprite_on_wr = hit_wr_p1;
    assign bus.sprite_on_dr = in_box(bus.DrawX, bus.DrawY, bus.PosX, bus.PosY);
    assign bus.frame_idx    = frame_idx_q;
    assign bus.anim_done    = (state == DONE);

endmodule

// File: tb/tb_anim_sprite_drawer.sv
// Bench for anim_sprite_drawer: two instances (2 frames/hold 10 and 3 frames/hold 1) driven in parallel.
module tb_anim_sprite_drawer;
    localparam int BASE = 207867;
    localparam int FPIX = 88 * 94;

    logic       Clk50 = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0, anim_en = 1'b0, anim_restart = 1'b0, mirror = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [9:0] wx = '0, wy = '0, dx = '0, dy = '0, px = '0, py = '0;

    int total = 0;
    int bad   = 0;

    always #5 Clk50 = ~Clk50;

    anim_sprite_drawer_if #(.ADDR_W(18), .COORD_W(10)) ifa ();
    anim_sprite_drawer_if #(.ADDR_W(18), .COORD_W(10)) ifb ();

    assign ifa.frame_tick = frame_tick;   assign ifb.frame_tick = frame_tick;
    assign ifa.anim_en = anim_en;         assign ifb.anim_en = anim_en;
    assign ifa.anim_restart = anim_restart; assign ifb.anim_restart = anim_restart;
    assign ifa.mode = mode;               assign ifb.mode = mode;
    assign ifa.mirror = mirror;           assign ifb.mirror = mirror;
    assign ifa.WriteX = wx;  assign ifa.WriteY = wy;  assign ifb.WriteX = wx;  assign ifb.WriteY = wy;
    assign ifa.DrawX = dx;   assign ifa.DrawY = dy;   assign ifb.DrawX = dx;   assign ifb.DrawY = dy;
    assign ifa.PosX = px;    assign ifa.PosY = py;    assign ifb.PosX = px;    assign ifb.PosY = py;

    anim_sprite_drawer #(.NUM_FRAMES(2), .HOLD_TICKS(10)) dut_a (
        .Clk50(Clk50), .Reset_n(Reset_n), .bus(ifa.slave));
    anim_sprite_drawer #(.NUM_FRAMES(3), .HOLD_TICKS(1)) dut_b (
        .Clk50(Clk50), .Reset_n(Reset_n), .bus(ifb.slave));

    typedef struct { int px; int py; int wx; int wy; int mir; int exp_addr; int exp_on; } wr_vec_t;
    typedef struct { int px; int py; int dx; int dy; int exp_on; } dr_vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk50);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; step();
        end
    endtask

    task automatic restart();
        anim_restart = 1'b1; step();
        anim_restart = 1'b0;
    endtask

    // Reference: frame index as a closed-form function of enabled ticks since restart.
    function automatic int m_idx(input int t, input int md, input int nf, input int hold);
        int adv, per, p;
        adv = t / hold;
        if (md == 1) return (adv >= nf - 1) ? nf - 1 : adv;
        if (md == 2) begin
            if (nf == 1) return 0;
            per = 2 * (nf - 1);
            p   = adv % per;
            return (p < nf) ? p : per - p;
        end
        return adv % nf;
    endfunction

    function automatic int m_done(input int t, input int md, input int nf, input int hold);
        return (md == 1 && (t / hold) >= ((nf > 1) ? nf - 1 : 1)) ? 1 : 0;
    endfunction

    function automatic int m_inside(input int x, input int y, input int bx, input int by);
        return (x >= bx && x < bx + 88 && y >= by && y < by + 94) ? 1 : 0;
    endfunction

    function automatic int m_addr(input int idx, input int x, input int y, input int bx, input int by,
                                  input int mir);
        int a;
        a = BASE + idx * FPIX;
        if (m_inside(x, y, bx, by) != 0)
            a = a + (y - by) * 88 + ((mir != 0) ? 87 - (x - bx) : (x - bx));
        return a & 32'h3FFFF;
    endfunction

    initial begin
        wr_vec_t wv[7];
        dr_vec_t dv[6];
        int pp[5];
        int tk, cur_md, ia, ib, ea, eb, eda, edb, edr;

        wv[0] = '{100, 200, 100, 200, 0, 207867, 1};
        wv[1] = '{100, 200, 187, 293, 0, 216138, 1};
        wv[2] = '{100, 200, 100, 200, 1, 207954, 1};
        wv[3] = '{100, 200, 187, 200, 1, 207867, 1};
        wv[4] = '{100, 200, 188, 200, 0, 207867, 0};
        wv[5] = '{100, 200, 100, 294, 0, 207867, 0};
        wv[6] = '{100, 200, 99, 250, 1, 207867, 0};
        dv[0] = '{1000, 0, 1020, 5, 1};
        dv[1] = '{1000, 0, 5, 5, 0};
        dv[2] = '{100, 200, 187, 293, 1};
        dv[3] = '{100, 200, 188, 293, 0};
        dv[4] = '{0, 1000, 50, 1023, 1};
        dv[5] = '{100, 200, 100, 199, 0};
        pp = '{1, 2, 1, 0, 1};

        // Reset values while held in reset
        repeat (2) step();
        chk("rst_idx", int'(ifa.frame_idx), 0);
        chk("rst_done", int'(ifa.anim_done), 0);
        chk("rst_addr", int'(ifa.address), BASE);
        chk("rst_on_wr", int'(ifa.sprite_on_wr), 0);
        #2 Reset_n = 1'b1;
        step();

        // Write-side address table (frame 0, no ticks)
        foreach (wv[i]) begin
            px = 10'(wv[i].px); py = 10'(wv[i].py);
            wx = 10'(wv[i].wx); wy = 10'(wv[i].wy); mirror = wv[i].mir[0];
            step();
            chk($sformatf("wr_addr[%0d]", i), int'(ifa.address), wv[i].exp_addr);
            chk($sformatf("wr_on[%0d]", i), int'(ifa.sprite_on_wr), wv[i].exp_on);
        end
        mirror = 1'b0;

        // Draw-side combinational hit table
        foreach (dv[i]) begin
            px = 10'(dv[i].px); py = 10'(dv[i].py);
            dx = 10'(dv[i].dx); dy = 10'(dv[i].dy);
            #1;
            chk($sformatf("dr_on[%0d]", i), int'(ifa.sprite_on_dr), dv[i].exp_on);
        end

        // LOOP, 20 ticks; address switches frame one cycle after the advancing tick
        px = 10'd100; py = 10'd200; wx = 10'd100; wy = 10'd200;
        mode = 2'd0; anim_en = 1'b1;
        restart();
        for (int i = 1; i <= 20; i++) begin
            frame_tick = 1'b1; step();
            chk($sformatf("loop_addr_t%0d", i), int'(ifa.address), BASE + (((i - 1) / 10) % 2) * FPIX);
            chk($sformatf("loop_idx_t%0d", i), int'(ifa.frame_idx), (i / 10) % 2);
            frame_tick = 1'b0; step();
        end

        // anim_en=0 freezes the hold count
        restart();
        ticks(5);
        anim_en = 1'b0; ticks(10);
        chk("freeze_idx", int'(ifa.frame_idx), 0);
        anim_en = 1'b1; ticks(5);
        chk("unfreeze_idx", int'(ifa.frame_idx), 1);

        // PINGPONG on the 3-frame, hold-1 instance
        mode = 2'd2;
        restart();
        for (int i = 0; i < 5; i++) begin
            ticks(1);
            chk($sformatf("pp_idx[%0d]", i), int'(ifb.frame_idx), pp[i]);
        end

        // ONESHOT: park on last frame, then restart coincident with a tick
        mode = 2'd1;
        restart();
        ticks(10);
        chk("os_idx", int'(ifa.frame_idx), 1);
        chk("os_done", int'(ifa.anim_done), 1);
        ticks(5);
        chk("os_park_idx", int'(ifa.frame_idx), 1);
        chk("os_park_done", int'(ifa.anim_done), 1);
        anim_restart = 1'b1; frame_tick = 1'b1; step();
        anim_restart = 1'b0; frame_tick = 1'b0;
        chk("os_rst_idx", int'(ifa.frame_idx), 0);
        chk("os_rst_done", int'(ifa.anim_done), 0);
        step();
        ticks(9);
        chk("os_hold_cleared", int'(ifa.frame_idx), 0);
        ticks(1);
        chk("os_after10", int'(ifa.frame_idx), 1);

        // Async reset mid-PLAY at idx 1, hold 5; outputs must clear before any edge
        mode = 2'd0;
        restart();
        ticks(15);
        wx = 10'd103; wy = 10'd202;
        step();
        chk("pre_rst_idx", int'(ifa.frame_idx), 1);
        chk("pre_rst_addr", int'(ifa.address), BASE + FPIX + 2 * 88 + 3);
        #1 Reset_n = 1'b0;
        #1;
        chk("async_idx", int'(ifa.frame_idx), 0);
        chk("async_done", int'(ifa.anim_done), 0);
        chk("async_addr", int'(ifa.address), BASE);
        chk("async_on_wr", int'(ifa.sprite_on_wr), 0);
        #1 Reset_n = 1'b1;

        // Randomized run against the closed-form model (mode fixed between restarts)
        tk = 0; cur_md = 0;
        for (int seg = 0; seg < 40; seg++) begin
            for (int c = 0; c < 60; c++) begin
                anim_restart = (c == 0 || $urandom_range(0, 39) == 0) ? 1'b1 : 1'b0;
                if (c == 0) mode = 2'($urandom_range(0, 3));
                frame_tick = 1'($urandom_range(0, 1));
                anim_en    = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
                mirror     = 1'($urandom_range(0, 1));
                px = 10'($urandom_range(0, 1023));
                py = 10'($urandom_range(0, 1023));
                wx = 10'(int'(px) + int'($urandom_range(0, 107)) - 10);
                wy = 10'(int'(py) + int'($urandom_range(0, 113)) - 10);
                dx = 10'(int'(px) + int'($urandom_range(0, 107)) - 10);
                dy = 10'(int'(py) + int'($urandom_range(0, 113)) - 10);
                ia = m_idx(tk, cur_md, 2, 10);
                ib = m_idx(tk, cur_md, 3, 1);
                ea = m_addr(ia, int'(wx), int'(wy), int'(px), int'(py), int'(mirror));
                eb = m_addr(ib, int'(wx), int'(wy), int'(px), int'(py), int'(mirror));
                edr = m_inside(int'(dx), int'(dy), int'(px), int'(py));
                step();
                if (anim_restart) begin
                    tk = 0;
                    cur_md = int'(mode);
                end else if (frame_tick && anim_en) begin
                    tk++;
                end
                eda = m_done(tk, cur_md, 2, 10);
                edb = m_done(tk, cur_md, 3, 1);
                chk("rnd_idx_a", int'(ifa.frame_idx), m_idx(tk, cur_md, 2, 10));
                chk("rnd_idx_b", int'(ifb.frame_idx), m_idx(tk, cur_md, 3, 1));
                chk("rnd_done_a", int'(ifa.anim_done), eda);
                chk("rnd_done_b", int'(ifb.anim_done), edb);
                chk("rnd_addr_a", int'(ifa.address), ea);
                chk("rnd_addr_b", int'(ifb.address), eb);
                chk("rnd_on_wr", int'(ifa.sprite_on_wr),
                    m_inside(int'(wx), int'(wy), int'(px), int'(py)));
                chk("rnd_on_dr", int'(ifa.sprite_on_dr), edr);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
